// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The op-decoding helpers keep the bit meanings of the op field in one place.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Combinational conditional two's-complement negation.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide producing a HI/LO pair.
// Operands are reduced to magnitudes on launch; signs are reapplied in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               r_state;
  state_e               w_next;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_dz;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mb;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  op_e                  w_op;
  logic                 w_sgn;
  logic                 w_accept;
  logic                 w_dz;
  logic                 w_last;
  logic                 w_fix_en;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_add;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH:0]       w_diff;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [2*WIDTH-1:0]   w_prod_fix;

  assign w_op     = op_e'(op);
  assign w_sgn    = op_is_signed(w_op);
  assign w_accept = start & ~abort & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_dz     = op_is_div(w_op) & (b == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_fix_en = (r_state == ST_FIX) & ~abort;

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (
    .i_val(a), .i_neg(w_sgn & a[WIDTH-1]), .o_val(w_mag_a)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (
    .i_val(b), .i_neg(w_sgn & b[WIDTH-1]), .o_val(w_mag_b)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_q (
    .i_val(r_quo), .i_neg(r_neg_q), .o_val(w_quo_fix)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_r (
    .i_val(r_rem), .i_neg(r_neg_r), .o_val(w_rem_fix)
  );
  muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_p (
    .i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod_fix)
  );

  // Shift-add step: conditionally add the multiplier into the upper half, then shift right.
  assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mb} : '0);
  assign w_acc_nxt = {w_add, r_acc[WIDTH-1:1]};

  // Restoring step: the sign of the trial difference is the next quotient bit (inverted).
  assign w_trial = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_mb};
  assign w_ge    = ~w_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_next = w_dz ? ST_DONE : ST_RUN;
        else          w_next = ST_IDLE;
      end
      ST_RUN: begin
        if (abort)       w_next = ST_IDLE;
        else if (w_last) w_next = ST_FIX;
      end
      ST_FIX:  w_next = abort ? ST_IDLE : ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_accept) begin
      r_is_div <= op_is_div(w_op);
      r_neg_q  <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r  <= w_sgn & a[WIDTH-1];
      r_dz     <= w_dz;
      r_cnt    <= '0;
      r_mb     <= w_mag_b;
      r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
      r_rem    <= '0;
      r_quo    <= w_mag_a;
      if (w_dz) begin
        r_hi <= a;
        r_lo <= '1;
      end
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_acc_nxt;
      r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
    end else if (w_fix_en) begin
      if (r_is_div) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end else begin
        {r_hi, r_lo} <= w_prod_fix;
      end
    end
  end

  assign busy     = (r_state == ST_RUN) | (r_state == ST_FIX);
  assign done     = (r_state == ST_DONE);
  assign div_zero = done & r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative, multicycle multiply/divide unit for the multicycle CPU datapath.
- Replaces the separate fixed-32-bit mult and div blocks with one shared datapath.
- Handles signed and unsigned multiply and divide, at any operand width.
- Produces the HI/LO pair consumed by the high/low registers, with a start/busy/done handshake driven by the control unit.
- Adds an abort input, so an exception can cancel an operation that is in flight.

Parameters:
- WIDTH, 32: operand width in bits. Legal range 4..64. hi and lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter. Derived; never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- start  in  1  launch request. Sampled only in IDLE or DONE.
- op  in  2  operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- a  in  WIDTH  multiplicand or dividend. Latched when start is accepted.
- b  in  WIDTH  multiplier or divisor. Latched when start is accepted.
- abort  in  1  cancels the operation in flight.
- busy  out  1  high while in RUN or FIX.
- done  out  1  one-cycle pulse; hi and lo are valid in the same cycle.
- div_zero  out  1  one-cycle pulse together with done when a divide has b == 0.
- hi  out  WIDTH  multiply: upper product half. Divide: remainder.
- lo  out  WIDTH  multiply: lower product half. Divide: quotient.

Behaviour:
- One clock domain. reset is synchronous and active-high. On reset: state = IDLE; busy, done, div_zero, hi, lo, counter and all internal registers = 0. Reset wins over every other input, including mid-operation.
- States: IDLE, RUN, FIX, DONE.
- Start is accepted in IDLE or DONE when start = 1 and abort = 0. On acceptance:
  - latch op;
  - latch |a| and |b| (two's-complement magnitude for signed ops, raw value for unsigned ops);
  - latch the result sign flags;
  - clear the counter.
- Divide with b == 0: go directly to DONE. hi = a (raw), lo = all ones, div_zero = 1 with done. No iteration.
- All other accepted ops go to RUN.
- RUN performs exactly WIDTH iterations, one per cycle, then moves to FIX:
  - multiply: shift-add on the 2*WIDTH accumulator;
  - divide: restoring division, one quotient bit per cycle.
- FIX applies sign correction and registers hi and lo, then moves to DONE.
  - MULT: negate the 2*WIDTH product if sign(a) XOR sign(b).
  - DIV: negate the quotient if sign(a) XOR sign(b); negate the remainder if sign(a).
- DONE asserts done for one cycle. Next state:
  - IDLE if no new start;
  - RUN, or DONE for a divide by zero, if a start is accepted in this cycle (back-to-back operation).
- Latency from the cycle in which start is sampled to the done cycle:
  - WIDTH+2 cycles for normal ops (34 for WIDTH=32);
  - 1 cycle for a divide by zero.
- hi and lo hold their values until the next FIX, or the next divide-by-zero acceptance. They are unchanged by abort.
- start while busy is ignored: no queueing, and operands are not re-latched.
- abort = 1 in RUN or FIX: next state is IDLE; no done; hi and lo keep their previous values.
- abort = 1 in IDLE or DONE suppresses a simultaneous start. abort always has priority over start.
- Overflow case, signed DIV with a = most-negative and b = -1: lo = most-negative (quotient wraps), hi = 0. No flag is raised.
- MULTU and DIVU never negate.
- Arithmetic is at WIDTH bits, with a WIDTH+1-bit partial remainder. Signed magnitude of the most-negative value is 2^(WIDTH-1), represented unsigned.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encodings ST_IDLE, ST_RUN, ST_FIX, ST_DONE.
- One sub-module is natural: muldiv_negate. It is a combinational conditional two's-complement with a parameter for width.
  - Instantiated at WIDTH for operand magnitudes and remainder/quotient correction.
  - Instantiated at 2*WIDTH for product correction.
- The FSM and the iteration datapath stay in muldiv_unit.

Test Plan (WIDTH=32):
- MULT, a=0xFFFFFFFD (-3), b=7 -> done exactly 34 cycles after start. hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy is high for 33 cycles.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Back-to-back start in the DONE cycle is accepted, with no idle gap.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU, a=0x12345678, b=0 -> done and div_zero high in the cycle after start. hi=0x12345678, lo=0xFFFFFFFF.
- Abort and ignored start:
  - Start DIVU 100/7 after a prior result hi=5, lo=9.
  - Assert abort in the 10th RUN cycle -> busy low next cycle, no done, hi=5 and lo=9 retained.
  - start pulses while busy -> ignored.
  - abort and start together in IDLE -> no launch.
- Reset mid-RUN -> next cycle: state IDLE, busy=0, hi=lo=0, no done. A new MULT then completes normally.
